rv_iter_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit implementing the RISC-V M-extension operations for an XLEN-bit datapath. It sits beside the EX-stage ALU. It accepts one operation through a valid/ready handshake and computes it over multiple cycles using shift-add and restoring-divide engines. It returns the result with its destination register tag. The EX stage holds the pipeline while the unit is busy, and a branch redirect can cancel an in-flight operation with `flush`.

---
 rtl/rv_iter_muldiv.sv | 217 +++++++++++++++++++++
 tb/tb_rv_iter_muldiv.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_iter_muldiv.sv
// Iterative RISC-V M-extension multiply/divide unit: shift-add multiplier and
// restoring divider sharing one 2*XLEN accumulator, one step per clock.
module rv_iter_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] ZERO_X = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES_X = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_X  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_r;
    logic [2:0]          op_r;
    logic [4:0]          rd_r;
    logic                a_neg_r;
    logic                b_neg_r;
    logic [XLEN-1:0]     a_mag_r;
    logic [XLEN-1:0]     b_mag_r;
    logic [2*XLEN-1:0]   acc_r;
    logic [CW-1:0]       cnt_r;
    logic [XLEN-1:0]     result_r;
    logic [4:0]          rd_out_r;
    logic                result_valid_r;

    logic                a_signed_s;
    logic                b_signed_s;
    logic                a_neg_s;
    logic                b_neg_s;
    logic [XLEN-1:0]     a_mag_s;
    logic [XLEN-1:0]     b_mag_s;
    logic                div_zero_s;
    logic                ovf_s;
    logic                special_s;
    logic [XLEN-1:0]     special_val_s;
    logic [XLEN:0]       mul_sum_s;
    logic [XLEN:0]       div_sh_s;
    logic [XLEN:0]       div_diff_s;
    logic [2*XLEN-1:0]   step_acc_s;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     fix_res_s;

    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    assign start_ready  = (state_r == IDLE);
    assign busy         = (state_r != IDLE);
    assign result_valid = result_valid_r;
    assign result       = result_r;
    assign rd_out       = rd_out_r;

    // Operand signedness, magnitudes and divide special cases at acceptance
    always_comb begin
        a_signed_s    = 1'b0;
        b_signed_s    = 1'b0;
        special_s     = 1'b0;
        special_val_s = ZERO_X;
        case (funct3)
            3'b001:         begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            3'b010:         begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
            3'b100, 3'b110: begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            default:        begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
        endcase
        a_neg_s    = a_signed_s & rs1_val[XLEN-1];
        b_neg_s    = b_signed_s & rs2_val[XLEN-1];
        a_mag_s    = a_neg_s ? neg_x(rs1_val) : rs1_val;
        b_mag_s    = b_neg_s ? neg_x(rs2_val) : rs2_val;
        div_zero_s = (rs2_val == ZERO_X);
        ovf_s      = (rs1_val == MIN_X) && (rs2_val == ONES_X);
        case (funct3)
            3'b100: begin
                special_s     = div_zero_s | ovf_s;
                special_val_s = div_zero_s ? ONES_X : rs1_val;
            end
            3'b101: begin
                special_s     = div_zero_s;
                special_val_s = ONES_X;
            end
            3'b110: begin
                special_s     = div_zero_s | ovf_s;
                special_val_s = div_zero_s ? rs1_val : ZERO_X;
            end
            3'b111: begin
                special_s     = div_zero_s;
                special_val_s = rs1_val;
            end
            default: begin
                special_s     = 1'b0;
                special_val_s = ZERO_X;
            end
        endcase
    end

    // One iteration: acc holds {partial product, multiplier} or {remainder, quotient}
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]}
                   + (acc_r[0] ? {1'b0, a_mag_r} : {(XLEN+1){1'b0}});
        div_sh_s   = acc_r[2*XLEN-1:XLEN-1];
        div_diff_s = div_sh_s - {1'b0, b_mag_r};
        if (op_r[2]) begin
            if (div_diff_s[XLEN]) begin
                step_acc_s = {div_sh_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
            end else begin
                step_acc_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
            end
        end else begin
            step_acc_s = {mul_sum_s, acc_r[XLEN-1:1]};
        end
    end

    // Sign fix-up and result selection
    always_comb begin
        prod_s = (a_neg_r ^ b_neg_r) ? (~acc_r + {{(2*XLEN-1){1'b0}}, 1'b1}) : acc_r;
        case (op_r)
            3'b000:                 fix_res_s = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res_s = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res_s = (a_neg_r ^ b_neg_r) ? neg_x(acc_r[XLEN-1:0])
                                                                    : acc_r[XLEN-1:0];
            3'b110, 3'b111:         fix_res_s = a_neg_r ? neg_x(acc_r[2*XLEN-1:XLEN])
                                                        : acc_r[2*XLEN-1:XLEN];
            default:                fix_res_s = ZERO_X;
        endcase
    end

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= IDLE;
            op_r           <= 3'b000;
            rd_r           <= 5'd0;
            a_neg_r        <= 1'b0;
            b_neg_r        <= 1'b0;
            a_mag_r        <= ZERO_X;
            b_mag_r        <= ZERO_X;
            acc_r          <= {(2*XLEN){1'b0}};
            cnt_r          <= {CW{1'b0}};
            result_r       <= ZERO_X;
            rd_out_r       <= 5'd0;
            result_valid_r <= 1'b0;
        end else if (flush) begin
            state_r        <= IDLE;
            result_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_valid) begin
                        op_r    <= funct3;
                        rd_r    <= rd_in;
                        a_neg_r <= a_neg_s;
                        b_neg_r <= b_neg_s;
                        a_mag_r <= a_mag_s;
                        b_mag_r <= b_mag_s;
                        if (special_s) begin
                            result_r       <= special_val_s;
                            rd_out_r       <= rd_in;
                            result_valid_r <= 1'b1;
                            state_r        <= DONE;
                        end else begin
                            acc_r          <= {ZERO_X, (funct3[2] ? a_mag_s : b_mag_s)};
                            cnt_r          <= CW'(XLEN - 1);
                            result_valid_r <= 1'b0;
                            state_r        <= CALC;
                        end
                    end else begin
                        result_valid_r <= 1'b0;
                        state_r        <= IDLE;
                    end
                end
                CALC: begin
                    acc_r          <= step_acc_s;
                    result_valid_r <= 1'b0;
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r <= FIX;
                    end else begin
                        cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                FIX: begin
                    result_r       <= fix_res_s;
                    rd_out_r       <= rd_r;
                    result_valid_r <= 1'b1;
                    state_r        <= DONE;
                end
                DONE: begin
                    result_valid_r <= 1'b0;
                    state_r        <= IDLE;
                end
                default: begin
                    result_valid_r <= 1'b0;
                    state_r        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_iter_muldiv.sv
// Scoreboard bench for rv_iter_muldiv: expected results and due cycles are
// queued at issue and compared when result_valid is seen.
module tb_rv_iter_muldiv;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            start_valid;
    logic            start_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd_in;
    logic            flush;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          due;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic        prev_v = 1'b0;
    logic [31:0] last_res = 32'd0;
    logic [4:0]  last_rd = 5'd0;

    rv_iter_muldiv #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
        .funct3(funct3), .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
        .flush(flush), .busy(busy), .result_valid(result_valid), .result(result),
        .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        logic [63:0]     p;
        int              ia = a;
        int              ib = b;
        case (f3)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * longint'(ub); return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        if (!f3[2]) return 1'b0;
        if (b == 32'd0) return 1'b1;
        return (f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // Issue one operation once the unit is ready; optionally queue its expectation
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit track, input string tag);
        int w = 0;
        @(negedge clk);
        while (!start_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!start_ready) begin
            check({tag, "_ready_timeout"}, 64'(start_ready), 64'd1);
        end else begin
            start_valid = 1'b1;
            funct3      = f3;
            rs1_val     = a;
            rs2_val     = b;
            rd_in       = rd;
            if (track) begin
                sb_q.push_back('{res: ref_op(f3, a, b), rd: rd,
                                 due: cyc + 1 + (is_special(f3, a, b) ? 0 : XLEN + 1),
                                 tag: tag});
            end
            @(negedge clk);
            start_valid = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int w = 0;
        while (sb_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sb_q.size() != 0) check({tag, "_drain_timeout"}, 64'(sb_q.size()), 64'd0);
    endtask

    // Result monitor: pops the scoreboard on each completion pulse
    always @(negedge clk) begin
        if (reset && result_valid) begin
            check("valid_twice", 64'(prev_v), 64'd0);
            check("valid_while_ready", 64'(start_ready), 64'd0);
            if (sb_q.size() == 0) begin
                check("spurious_valid", 64'(result_valid), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.tag, "_result"}, 64'(result), 64'(mon_e.res));
                check({mon_e.tag, "_rd"}, 64'(rd_out), 64'(mon_e.rd));
                check({mon_e.tag, "_latency"}, 64'(cyc), 64'(mon_e.due));
                last_res = mon_e.res;
                last_rd  = mon_e.rd;
            end
        end
        prev_v = result_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;
        reset       = 1'b0;
        start_valid = 1'b0;
        flush       = 1'b0;
        funct3      = 3'b000;
        rs1_val     = 32'd0;
        rs2_val     = 32'd0;
        rd_in       = 5'd0;
        repeat (2) @(negedge clk);
        check("rst_result", 64'(result), 64'd0);
        check("rst_rd", 64'(rd_out), 64'd0);
        check("rst_valid", 64'(result_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(start_ready), 64'd1);
        reset = 1'b1;

        // MUL signed operand, busy must hold until completion
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1, "mul");
        bad = 1'b0;
        for (int i = 0; i < XLEN + 1; i++) begin
            if (!busy) bad = 1'b1;
            @(negedge clk);
        end
        check("mul_busy", 64'(bad), 64'd0);
        drain("mul");

        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 1'b1, "mulh");
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1, "mulhu");
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1, "mulhsu");
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1, "div");
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1, "rem");
        issue(3'b101, 32'd100, 32'd7, 5'd7, 1'b1, "divu");
        issue(3'b111, 32'd100, 32'd7, 5'd8, 1'b1, "remu");
        drain("arith");

        issue(3'b100, 32'd5, 32'd0, 5'd9, 1'b1, "div0");
        issue(3'b111, 32'd5, 32'd0, 5'd10, 1'b1, "remu0");
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b1, "div_ovf");
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b1, "rem_ovf");
        drain("special");

        for (int i = 0; i < 8; i++) begin
            issue(3'($urandom_range(7, 0)), $urandom, $urandom, 5'($urandom_range(31, 0)),
                  1'b1, "rand");
        end
        drain("rand");

        // Flush on the tenth CALC cycle
        issue(3'b101, 32'd1000, 32'd3, 5'd13, 1'b0, "flushed");
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready", 64'(start_ready), 64'd1);
        check("flush_valid", 64'(result_valid), 64'd0);
        check("flush_keep_result", 64'(result), 64'(last_res));
        check("flush_keep_rd", 64'(rd_out), 64'(last_rd));
        repeat (40) @(negedge clk);
        issue(3'b000, 32'd3, 32'd4, 5'd14, 1'b1, "mul_after_flush");
        drain("mul_after_flush");

        // Start while busy must be ignored
        issue(3'b101, 32'd100, 32'd7, 5'd15, 1'b1, "busy_first");
        start_valid = 1'b1;
        funct3      = 3'b000;
        rs1_val     = 32'd9;
        rs2_val     = 32'd9;
        rd_in       = 5'd3;
        repeat (5) @(negedge clk);
        start_valid = 1'b0;
        drain("busy_first");
        repeat (40) @(negedge clk);

        // Flush and start together in IDLE: nothing accepted
        @(negedge clk);
        start_valid = 1'b1;
        flush       = 1'b1;
        funct3      = 3'b101;
        rs1_val     = 32'd50;
        rs2_val     = 32'd5;
        @(negedge clk);
        start_valid = 1'b0;
        flush       = 1'b0;
        check("flush_start_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);

        // Asynchronous reset in the middle of CALC
        issue(3'b100, 32'd1234, 32'd7, 5'd20, 1'b0, "reset_op");
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_rd", 64'(rd_out), 64'd0);
        check("midrst_valid", 64'(result_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_ready", 64'(start_ready), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        repeat (45) @(negedge clk);
        check("post_reset_result", 64'(result), 64'd0);
        check("post_reset_queue", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
